shift_arbiter: RTL and testbench

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_arbiter.sv | 250 +++++++++++++++++++++++++
 tb/tb_shift_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

// barrel_shifter: ARM-style LSL/LSR/ASR/ROR with immediate #0 specials (LSR/ASR #32, RRX).
// Latency: purely combinational.
// Backpressure: none; the caller owns all flow control.
module barrel_shifter #(
    parameter int DATA_WIDTH = `DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [4:0]            shamt,
    input  logic [1:0]            shift_type,
    input  logic                  cin,
    input  logic                  is_imm_shift,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  cout
);
    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    // One guard bit on the shifted-out side carries the last bit lost into cout.
    logic [DATA_WIDTH:0]     lsl_ext;
    logic [DATA_WIDTH:0]     lsr_ext;
    logic [DATA_WIDTH:0]     asr_ext;
    logic [2*DATA_WIDTH-1:0] ror_ext;

    assign lsl_ext = {1'b0, din} << shamt;
    assign lsr_ext = {din, 1'b0} >> shamt;
    assign asr_ext = $signed({din, 1'b0}) >>> shamt;
    assign ror_ext = {din, din} >> shamt;

    always_comb begin
        dout = din;
        cout = cin;
        if (shamt == 5'd0) begin
            if (is_imm_shift) begin
                unique case (shift_type)
                    SH_LSR: begin
                        dout = '0;
                        cout = din[DATA_WIDTH-1];
                    end
                    SH_ASR: begin
                        dout = {DATA_WIDTH{din[DATA_WIDTH-1]}};
                        cout = din[DATA_WIDTH-1];
                    end
                    SH_ROR: begin
                        dout = {cin, din[DATA_WIDTH-1:1]};
                        cout = din[0];
                    end
                    default: begin
                        dout = din;
                        cout = cin;
                    end
                endcase
            end
        end else begin
            unique case (shift_type)
                SH_LSL: begin
                    dout = lsl_ext[DATA_WIDTH-1:0];
                    cout = lsl_ext[DATA_WIDTH];
                end
                SH_LSR: begin
                    dout = lsr_ext[DATA_WIDTH:1];
                    cout = lsr_ext[0];
                end
                SH_ASR: begin
                    dout = asr_ext[DATA_WIDTH:1];
                    cout = asr_ext[0];
                end
                default: begin
                    dout = ror_ext[DATA_WIDTH-1:0];
                    cout = ror_ext[DATA_WIDTH-1];
                end
            endcase
        end
    end
endmodule

// shift_arbiter: two requesters share one barrel shifter through a one-entry result register.
// Latency: 1 cycle from transfer to resp_valid; drain and accept overlap for full throughput.
// Backpressure: req_ready is 00 while the result is held and resp_ready is low.
module shift_arbiter #(
    parameter int DATA_WIDTH = `DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [2*DATA_WIDTH-1:0] req_din,
    input  logic [15:0]             req_amt,
    input  logic [3:0]              req_type,
    input  logic [1:0]              req_cin,
    input  logic [1:0]              req_imm,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_dout,
    output logic                    resp_cout,
    output logic                    resp_id
);
    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  cout_q, cout_d;
    logic                  id_q, id_d;
    logic                  last_grant_q, last_grant_d;

    logic                  slot_free;
    logic                  gnt_vld;
    logic                  gnt_id;
    logic                  xfer;

    logic [DATA_WIDTH-1:0] sel_din;
    logic [7:0]            sel_amt;
    logic [1:0]            sel_type;
    logic                  sel_cin;
    logic                  sel_imm;

    logic [4:0]            sh_shamt;
    logic                  sh_imm;
    logic [DATA_WIDTH-1:0] sh_dout;
    logic                  sh_cout;

    logic                  ovr;
    logic [DATA_WIDTH-1:0] ovr_dout;
    logic                  ovr_cout;
    logic [DATA_WIDTH-1:0] res_dout;
    logic                  res_cout;

    // Round-robin on ties: favour whoever did not win the last transfer.
    always_comb begin
        gnt_vld = |req_valid;
        gnt_id  = 1'b0;
        unique case (req_valid)
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = ~last_grant_q;
            default: gnt_id = 1'b0;
        endcase
    end

    assign slot_free = (state_q == EMPTY) || resp_ready;
    assign req_ready = (!rst && slot_free && gnt_vld) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
    assign xfer      = |(req_valid & req_ready);

    assign sel_din  = gnt_id ? req_din[2*DATA_WIDTH-1:DATA_WIDTH] : req_din[DATA_WIDTH-1:0];
    assign sel_amt  = gnt_id ? req_amt[15:8] : req_amt[7:0];
    assign sel_type = gnt_id ? req_type[3:2] : req_type[1:0];
    assign sel_cin  = gnt_id ? req_cin[1]    : req_cin[0];
    assign sel_imm  = gnt_id ? req_imm[1]    : req_imm[0];

    // Register amounts of 32 and above never reach the shifter; they are resolved here.
    always_comb begin
        sh_shamt = sel_amt[4:0];
        sh_imm   = sel_imm;
        ovr      = 1'b0;
        ovr_dout = '0;
        ovr_cout = 1'b0;
        if (!sel_imm && (sel_amt[7:5] != 3'd0)) begin
            unique case (sel_type)
                SH_LSL: begin
                    ovr      = 1'b1;
                    ovr_cout = (sel_amt == 8'd32) ? sel_din[0] : 1'b0;
                end
                SH_LSR: begin
                    ovr      = 1'b1;
                    ovr_cout = (sel_amt == 8'd32) ? sel_din[DATA_WIDTH-1] : 1'b0;
                end
                SH_ASR: begin
                    ovr      = 1'b1;
                    ovr_dout = {DATA_WIDTH{sel_din[DATA_WIDTH-1]}};
                    ovr_cout = sel_din[DATA_WIDTH-1];
                end
                default: begin
                    if (sel_amt[4:0] == 5'd0) begin
                        ovr      = 1'b1;
                        ovr_dout = sel_din;
                        ovr_cout = sel_din[DATA_WIDTH-1];
                    end
                end
            endcase
            if (ovr) begin
                sh_shamt = 5'd0;
            end
        end
    end

    barrel_shifter #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_shifter (
        .din          (sel_din),
        .shamt        (sh_shamt),
        .shift_type   (sel_type),
        .cin          (sel_cin),
        .is_imm_shift (sh_imm),
        .dout         (sh_dout),
        .cout         (sh_cout)
    );

    assign res_dout = ovr ? ovr_dout : sh_dout;
    assign res_cout = ovr ? ovr_cout : sh_cout;

    always_comb begin
        state_d      = state_q;
        dout_d       = dout_q;
        cout_d       = cout_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        if (xfer) begin
            state_d      = FULL;
            dout_d       = res_dout;
            cout_d       = res_cout;
            id_d         = gnt_id;
            last_grant_d = gnt_id;
        end else if ((state_q == FULL) && resp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            dout_q       <= '0;
            cout_q       <= 1'b0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            dout_q       <= dout_d;
            cout_q       <= cout_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign resp_valid = (state_q == FULL);
    assign resp_dout  = dout_q;
    assign resp_cout  = cout_q;
    assign resp_id    = id_q;

    a_ready_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: hand-computed results for shifts, arbitration order,
// backpressure hold and reset, all checked through one compare task.
module tb_shift_arbiter;
    localparam logic [1:0] LSL = 2'b00;
    localparam logic [1:0] LSR = 2'b01;
    localparam logic [1:0] ASR = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_din;
    logic [15:0] req_amt;
    logic [3:0]  req_type;
    logic [1:0]  req_cin;
    logic [1:0]  req_imm;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_dout;
    logic        resp_cout;
    logic        resp_id;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    shift_arbiter #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_din    (req_din),
        .req_amt    (req_amt),
        .req_type   (req_type),
        .req_cin    (req_cin),
        .req_imm    (req_imm),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_dout  (resp_dout),
        .resp_cout  (resp_cout),
        .resp_id    (resp_id)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] din, input logic [7:0] amt,
                           input logic [1:0] ty, input logic cin, input logic imm);
        req_din[i*32 +: 32] = din;
        req_amt[i*8 +: 8]   = amt;
        req_type[i*2 +: 2]  = ty;
        req_cin[i]          = cin;
        req_imm[i]          = imm;
    endtask

    // Single-requester transfer; inputs are scrambled right after the edge to show they are not needed.
    task automatic one(input string tag, input int i, input logic [31:0] din, input logic [7:0] amt,
                       input logic [1:0] ty, input logic cin, input logic imm,
                       input logic [31:0] exp_d, input logic exp_c);
        set_req(i, din, amt, ty, cin, imm);
        req_valid = (i == 0) ? 2'b01 : 2'b10;
        #1;
        chk({tag, "_rdy"}, {30'd0, req_ready}, (i == 0) ? 32'd1 : 32'd2);
        tick();
        req_valid = 2'b00;
        set_req(i, ~din, ~amt, ~ty, ~cin, ~imm);
        chk({tag, "_vld"},  {31'd0, resp_valid}, 32'd1);
        chk({tag, "_dout"}, resp_dout, exp_d);
        chk({tag, "_cout"}, {31'd0, resp_cout}, {31'd0, exp_c});
        chk({tag, "_id"},   {31'd0, resp_id}, i[31:0]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 2'b00;
        req_din    = '0;
        req_amt    = '0;
        req_type   = '0;
        req_cin    = '0;
        req_imm    = '0;
        resp_ready = 1'b1;
        tick();
        tick();

        // Reset state and ready held low during reset even with requests pending.
        req_valid = 2'b11;
        #1;
        chk("rst_rdy",  {30'd0, req_ready}, 32'd0);
        chk("rst_vld",  {31'd0, resp_valid}, 32'd0);
        chk("rst_dout", resp_dout, 32'd0);
        chk("rst_cout", {31'd0, resp_cout}, 32'd0);
        chk("rst_id",   {31'd0, resp_id}, 32'd0);
        rst       = 1'b0;
        req_valid = 2'b00;

        one("imm_lsl1", 0, 32'h8000_0001, 8'd1, LSL, 1'b0, 1'b1, 32'h0000_0002, 1'b1);
        one("imm_rrx",  1, 32'h0000_0001, 8'd0, ROR, 1'b1, 1'b1, 32'h8000_0000, 1'b1);

        // Alternating grants with no bubbles; last winner was requester 1.
        set_req(0, 32'h1111_1111, 8'd0, LSL, 1'b0, 1'b0);
        set_req(1, 32'h0000_F000, 8'd4, LSR, 1'b0, 1'b0);
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("rr%0d_vld", k),  {31'd0, resp_valid}, 32'd1);
            chk($sformatf("rr%0d_id", k),   {31'd0, resp_id}, k % 2);
            chk($sformatf("rr%0d_dout", k), resp_dout, (k % 2 == 1) ? 32'h0000_0F00 : 32'h1111_1111);
        end
        req_valid = 2'b00;
        tick();
        chk("drain_vld", {31'd0, resp_valid}, 32'd0);

        one("lsr32",    0, 32'h8000_0000, 8'd32,  LSR, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
        one("lsr40",    0, 32'h8000_0000, 8'd40,  LSR, 1'b1, 1'b0, 32'h0000_0000, 1'b0);
        one("asr200",   1, 32'h8000_0000, 8'd200, ASR, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1);
        one("ror64",    0, 32'h1234_5678, 8'd64,  ROR, 1'b1, 1'b0, 32'h1234_5678, 1'b0);
        one("ror36",    1, 32'h1234_5678, 8'd36,  ROR, 1'b0, 1'b0, 32'h8123_4567, 1'b1);
        one("lsl32",    0, 32'h0000_0001, 8'd32,  LSL, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
        one("lsl33",    1, 32'hFFFF_FFFF, 8'd33,  LSL, 1'b1, 1'b0, 32'h0000_0000, 1'b0);
        one("imm_lsr0", 0, 32'h8000_0000, 8'd0,   LSR, 1'b0, 1'b1, 32'h0000_0000, 1'b1);
        one("imm_asr0", 1, 32'h8000_0000, 8'd0,   ASR, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        one("reg_ror0", 0, 32'h0000_0005, 8'd0,   ROR, 1'b1, 1'b0, 32'h0000_0005, 1'b1);
        one("imm_ror8", 1, 32'h0000_00AB, 8'd8,   ROR, 1'b0, 1'b1, 32'hAB00_0000, 1'b1);
        one("reg_lsl4", 0, 32'hF000_0001, 8'd4,   LSL, 1'b0, 1'b0, 32'h0000_0010, 1'b1);
        one("reg_asr4", 1, 32'h8000_0008, 8'd4,   ASR, 1'b0, 1'b0, 32'hF800_0000, 1'b1);

        // Backpressure: held result from requester 1, requester 0 waits.
        one("bp_load",  1, 32'h0000_00F0, 8'd4,   LSR, 1'b0, 1'b0, 32'h0000_000F, 1'b0);
        resp_ready = 1'b0;
        set_req(0, 32'h0000_0003, 8'd2, LSL, 1'b0, 1'b0);
        req_valid = 2'b01;
        #1;
        chk("bp_rdy_pre", {30'd0, req_ready}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("bp%0d_rdy", k),  {30'd0, req_ready}, 32'd0);
            chk($sformatf("bp%0d_vld", k),  {31'd0, resp_valid}, 32'd1);
            chk($sformatf("bp%0d_dout", k), resp_dout, 32'h0000_000F);
            chk($sformatf("bp%0d_id", k),   {31'd0, resp_id}, 32'd1);
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_rdy_rel", {30'd0, req_ready}, 32'd1);
        tick();
        req_valid = 2'b00;
        chk("bp_new_vld",  {31'd0, resp_valid}, 32'd1);
        chk("bp_new_dout", resp_dout, 32'h0000_000C);
        chk("bp_new_id",   {31'd0, resp_id}, 32'd0);

        // Reset while full; last winner was 0, so only reset makes a tie go to 0.
        rst = 1'b1;
        tick();
        chk("mid_rst_vld",  {31'd0, resp_valid}, 32'd0);
        chk("mid_rst_dout", resp_dout, 32'd0);
        rst = 1'b0;
        set_req(0, 32'hCAFE_F00D, 8'd0, LSL, 1'b1, 1'b1);
        set_req(1, 32'h0000_0001, 8'd1, LSL, 1'b0, 1'b1);
        req_valid = 2'b11;
        #1;
        chk("post_rst_rdy", {30'd0, req_ready}, 32'd1);
        tick();
        req_valid = 2'b00;
        chk("post_rst_id",   {31'd0, resp_id}, 32'd0);
        chk("post_rst_dout", resp_dout, 32'hCAFE_F00D);
        chk("post_rst_cout", {31'd0, resp_cout}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
